// File: rtl/puf_ro_ctrl.sv
// Ring-oscillator PUF measurement sequencer: picks LFSR-driven oscillator pairs,
// times the enable window, compares edge counts and accumulates the response word.
module puf_ro_ctrl #(
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned RESP_BITS  = 32,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 up_clk,
    input  logic                 up_rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          seed,
    input  logic [15:0]          window,
    input  logic [CNT_WIDTH-1:0] cnt_a,
    input  logic [CNT_WIDTH-1:0] cnt_b,
    output logic [SEL_WIDTH-1:0] ro_sel_a,
    output logic [SEL_WIDTH-1:0] ro_sel_b,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          response,
    output logic [5:0]           tie_count
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [31:0]          r_lfsr,    w_lfsr_nxt;
    logic [5:0]           r_bit_idx, w_bit_idx_nxt;
    logic [15:0]          r_win_len, w_win_len_nxt;
    logic [15:0]          r_timer,   w_timer_nxt;
    logic [SEL_WIDTH-1:0] r_sel_a,   w_sel_a_nxt;
    logic [SEL_WIDTH-1:0] r_sel_b,   w_sel_b_nxt;
    logic                 r_ro_en,   w_ro_en_nxt;
    logic                 r_cnt_clr, w_cnt_clr_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_done,    w_done_nxt;
    logic [31:0]          r_resp,    w_resp_nxt;
    logic [5:0]           r_ties,    w_ties_nxt;

    logic [SEL_WIDTH-1:0] w_pick_a;
    logic [SEL_WIDTH-1:0] w_pick_b;
    logic [31:0]          w_lfsr_step;
    logic                 w_tie;
    logic                 w_bit;

    assign w_pick_a    = r_lfsr[SEL_WIDTH-1:0];
    assign w_pick_b    = r_lfsr[2*SEL_WIDTH-1:SEL_WIDTH];
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_tie       = (cnt_a == cnt_b);
    assign w_bit       = (cnt_a > cnt_b);

    always_comb begin
        w_state_nxt   = r_state;
        w_lfsr_nxt    = r_lfsr;
        w_bit_idx_nxt = r_bit_idx;
        w_win_len_nxt = r_win_len;
        w_timer_nxt   = r_timer;
        w_sel_a_nxt   = r_sel_a;
        w_sel_b_nxt   = r_sel_b;
        w_ro_en_nxt   = r_ro_en;
        w_cnt_clr_nxt = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_resp_nxt    = r_resp;
        w_ties_nxt    = r_ties;

        // abort outranks everything; partial response, ties and selects are kept
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_ro_en_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_lfsr_nxt    = (seed == '0) ? 32'h1 : seed;
                        w_bit_idx_nxt = '0;
                        w_resp_nxt    = '0;
                        w_ties_nxt    = '0;
                        w_win_len_nxt = (window == '0) ? 16'd1 : window;
                        w_busy_nxt    = 1'b1;
                        w_cnt_clr_nxt = 1'b1;
                        w_state_nxt   = S_SELECT;
                    end
                end
                S_SELECT: begin
                    w_sel_a_nxt = w_pick_a;
                    w_sel_b_nxt = (w_pick_b == w_pick_a) ? (w_pick_a ^ SEL_WIDTH'(1)) : w_pick_b;
                    w_timer_nxt = r_win_len;
                    w_ro_en_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_timer_nxt = r_timer - 16'd1;
                    if (r_timer == 16'd1) begin
                        w_ro_en_nxt = 1'b0;
                        w_timer_nxt = 16'(SETTLE_CYC);
                        w_state_nxt = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    w_timer_nxt = r_timer - 16'd1;
                    if (r_timer == 16'd1) begin
                        w_state_nxt = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    w_resp_nxt    = {r_resp[30:0], w_bit};
                    if (w_tie && (r_ties != 6'd63)) begin
                        w_ties_nxt = r_ties + 6'd1;
                    end
                    w_lfsr_nxt    = w_lfsr_step;
                    w_bit_idx_nxt = r_bit_idx + 6'd1;
                    if (r_bit_idx == 6'(RESP_BITS - 1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_clr_nxt = 1'b1;
                        w_state_nxt   = S_SELECT;
                    end
                end
                S_DONE: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state   <= S_IDLE;
            r_lfsr    <= '0;
            r_bit_idx <= '0;
            r_win_len <= '0;
            r_timer   <= '0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            r_ro_en   <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_resp    <= '0;
            r_ties    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_win_len <= w_win_len_nxt;
            r_timer   <= w_timer_nxt;
            r_sel_a   <= w_sel_a_nxt;
            r_sel_b   <= w_sel_b_nxt;
            r_ro_en   <= w_ro_en_nxt;
            r_cnt_clr <= w_cnt_clr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_resp    <= w_resp_nxt;
            r_ties    <= w_ties_nxt;
        end
    end

    assign ro_sel_a  = r_sel_a;
    assign ro_sel_b  = r_sel_b;
    assign ro_en     = r_ro_en;
    assign cnt_clr   = r_cnt_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign response  = r_resp;
    assign tie_count = r_ties;

endmodule

// File: tb/tb_puf_ro_ctrl.sv
// Directed bench for puf_ro_ctrl with stub oscillator counters and a reference response model.
module tb_puf_ro_ctrl;

    logic        up_clk;
    logic        up_rstn;
    logic        start;
    logic        abort;
    logic [31:0] seed;
    logic [15:0] window;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [3:0]  ro_sel_a;
    logic [3:0]  ro_sel_b;
    logic        ro_en;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic [31:0] response;
    logic [5:0]  tie_count;

    logic        tie_mode;
    int          n_chk;
    int          n_bad;

    int          g_kdone;
    int          g_nen;
    int          g_nclr;
    int          g_novl;
    logic [3:0]  g_a1;
    logic [3:0]  g_b1;
    logic        g_en_ab;
    logic        g_busy_ab;
    logic        g_done_ab;
    logic [31:0] ref1;

    puf_ro_ctrl #(
        .SEL_WIDTH  (4),
        .CNT_WIDTH  (16),
        .RESP_BITS  (32),
        .SETTLE_CYC (4)
    ) dut (
        .up_clk    (up_clk),
        .up_rstn   (up_rstn),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .window    (window),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .ro_sel_a  (ro_sel_a),
        .ro_sel_b  (ro_sel_b),
        .ro_en     (ro_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .response  (response),
        .tie_count (tie_count)
    );

    initial up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    always_comb begin
        if (tie_mode) begin
            cnt_a = 16'd100;
            cnt_b = 16'd100;
        end else begin
            cnt_a = 16'(10 * (32'(ro_sel_a) + 1));
            cnt_b = 16'(10 * (32'(ro_sel_b) + 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stub counts are 10*(sel+1) so a bit is simply (sel_a > sel_b); pairs never tie.
    function automatic logic [31:0] model(input logic [31:0] s);
        logic [31:0] lfsr;
        logic [31:0] r;
        logic [3:0]  a;
        logic [3:0]  b;
        lfsr = (s == 32'h0) ? 32'h1 : s;
        r    = 32'h0;
        for (int i = 0; i < 32; i++) begin
            a = lfsr[3:0];
            b = lfsr[7:4];
            if (b == a) b = a ^ 4'h1;
            r = {r[30:0], (a > b)};
            lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        return r;
    endfunction

    // Called at #1 after an edge. k=1 is the cycle right after the accepting edge.
    task automatic run(input logic [31:0] s, input logic [15:0] w,
                       input int sk, input int ak, input int mk);
        seed   = s;
        window = w;
        start  = 1'b1;
        @(posedge up_clk);
        #1;
        start     = 1'b0;
        g_kdone   = 0;
        g_nen     = 0;
        g_nclr    = 0;
        g_novl    = 0;
        g_a1      = 4'hx;
        g_b1      = 4'hx;
        g_en_ab   = 1'bx;
        g_busy_ab = 1'bx;
        g_done_ab = 1'b0;
        for (int k = 1; k <= mk; k++) begin
            if (k > 1) begin
                @(posedge up_clk);
                #1;
            end
            if (ro_en) g_nen++;
            if (cnt_clr) g_nclr++;
            if (ro_en && cnt_clr) g_novl++;
            if (k == 2) begin
                g_a1 = ro_sel_a;
                g_b1 = ro_sel_b;
            end
            if ((ak != 0) && (k == ak + 1)) begin
                g_en_ab   = ro_en;
                g_busy_ab = busy;
            end
            if ((ak != 0) && (k > ak) && done) g_done_ab = 1'b1;
            if (done) begin
                g_kdone = k;
                break;
            end
            start = (k == sk);
            abort = (k == ak);
            seed  = (k == sk) ? 32'h33 : s;
        end
        start = 1'b0;
        abort = 1'b0;
        seed  = s;
    endtask

    task automatic after_done(input string tag);
        @(posedge up_clk);
        #1;
        chk({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        up_rstn  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        seed     = 32'h0;
        window   = 16'h0;
        tie_mode = 1'b0;
        ref1     = model(32'h1);

        repeat (2) @(posedge up_clk);
        #1;
        chk("rst_ctl", {26'h0, ro_sel_a, ro_sel_b, ro_en, cnt_clr, busy, done}, 32'h0);
        chk("rst_resp", response, 32'h0);
        chk("rst_ties", {26'h0, tie_count}, 32'h0);
        up_rstn = 1'b1;
        @(posedge up_clk);
        #1;

        // basic run, seed 1, window 8: 14 cycles per bit
        run(32'h1, 16'd8, 0, 0, 3000);
        chk("basic_done_k", g_kdone, 32'd449);
        chk("basic_en_cycles", g_nen, 32'd256);
        chk("basic_clr_cycles", g_nclr, 32'd32);
        chk("basic_overlap", g_novl, 32'd0);
        chk("basic_sel_a0", {28'h0, g_a1}, 32'd1);
        chk("basic_sel_b0", {28'h0, g_b1}, 32'd0);
        chk("basic_resp_top", {28'h0, response[31:28]}, 32'hF);
        chk("basic_resp", response, ref1);
        chk("basic_ties", {26'h0, tie_count}, 32'd0);
        after_done("basic");
        chk("basic_resp_hold", response, ref1);

        run(32'h0, 16'd8, 0, 0, 3000);
        chk("seed0_done_k", g_kdone, 32'd449);
        chk("seed0_resp", response, ref1);
        after_done("seed0");

        tie_mode = 1'b1;
        run(32'h1, 16'd8, 0, 0, 3000);
        chk("tie_done_k", g_kdone, 32'd449);
        chk("tie_resp", response, 32'h0);
        chk("tie_ties", {26'h0, tie_count}, 32'd32);
        after_done("tie");
        tie_mode = 1'b0;

        // seed 0x33: lfsr[3:0]==lfsr[7:4]==3, so B becomes 3^1
        run(32'h33, 16'd8, 0, 0, 3000);
        chk("coll_sel_a0", {28'h0, g_a1}, 32'd3);
        chk("coll_sel_b0", {28'h0, g_b1}, 32'd2);
        chk("coll_resp", response, model(32'h33));
        chk("coll_ties", {26'h0, tie_count}, 32'd0);
        after_done("coll");

        run(32'h1, 16'd0, 0, 0, 3000);
        chk("win0_done_k", g_kdone, 32'd225);
        chk("win0_en_cycles", g_nen, 32'd32);
        chk("win0_overlap", g_novl, 32'd0);
        chk("win0_resp", response, ref1);
        after_done("win0");

        // bit 5: SELECT at k=71, RUN k=72..79; abort sampled at end of k=74
        run(32'h1, 16'd8, 0, 74, 200);
        chk("abort_ro_en", {31'h0, g_en_ab}, 32'h0);
        chk("abort_busy", {31'h0, g_busy_ab}, 32'h0);
        chk("abort_no_done", {31'h0, g_done_ab}, 32'h0);
        chk("abort_done_k", g_kdone, 32'd0);
        chk("abort_partial", response, ref1 >> 27);
        run(32'h1, 16'd8, 0, 0, 3000);
        chk("abort_rerun_k", g_kdone, 32'd449);
        chk("abort_rerun_resp", response, ref1);
        after_done("abort_rerun");

        // start pulse with a different seed during RUN of bit 10
        run(32'h1, 16'd8, 144, 0, 3000);
        chk("busy_start_k", g_kdone, 32'd449);
        chk("busy_start_resp", response, ref1);
        after_done("busy_start");

        // asynchronous reset in the middle of a RUN window
        seed   = 32'h1;
        window = 16'd8;
        start  = 1'b1;
        @(posedge up_clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge up_clk);
        #2;
        chk("mid_pre_ro_en", {31'h0, ro_en}, 32'h1);
        up_rstn = 1'b0;
        #1;
        chk("mid_rst_ctl", {26'h0, ro_sel_a, ro_sel_b, ro_en, cnt_clr, busy, done}, 32'h0);
        chk("mid_rst_resp", response, 32'h0);
        chk("mid_rst_ties", {26'h0, tie_count}, 32'h0);
        @(posedge up_clk);
        #1;
        up_rstn = 1'b1;
        @(posedge up_clk);
        #1;
        chk("mid_idle_busy", {31'h0, busy}, 32'h0);
        run(32'h1, 16'd8, 0, 0, 3000);
        chk("mid_rerun_k", g_kdone, 32'd449);
        chk("mid_rerun_resp", response, ref1);
        after_done("mid_rerun");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
